// File: rtl/sti_feeder.sv
// Command feeder: fetches 22-bit command words from memory and hands each one
// to the serial transmitter, then raises pi_end for the pixel arranger.
module sti_feeder (
  input  logic        clk,
  input  logic        reset,
  input  logic        start,
  output logic [7:0]  cmd_addr,
  output logic        cmd_rd,
  input  logic [21:0] cmd_rdata,
  output logic        load,
  output logic        pi_low,
  output logic        pi_msb,
  output logic        pi_fill,
  output logic        pi_end,
  output logic [1:0]  pi_length,
  output logic [15:0] pi_data,
  input  logic        so_valid,
  input  logic        pixel_finish,
  output logic        busy,
  output logic        done,
  output logic        err,
  output logic [8:0]  cmd_count
);

  typedef enum logic [2:0] {
    S_IDLE, S_FETCH, S_CAPTURE, S_LOAD, S_WAIT_START, S_WAIT_END, S_END, S_DONE
  } state_t;

  state_t      state_q, state_d;
  logic [7:0]  cmd_addr_q, cmd_addr_d;
  logic [8:0]  cmd_count_q, cmd_count_d;
  logic [15:0] pi_data_q, pi_data_d;
  logic [1:0]  pi_length_q, pi_length_d;
  logic        pi_fill_q, pi_fill_d;
  logic        pi_msb_q, pi_msb_d;
  logic        pi_low_q, pi_low_d;
  logic        last_q, last_d;
  logic [2:0]  timeout_q, timeout_d;
  logic        cmd_rd_q, cmd_rd_d;
  logic        load_q, load_d;
  logic        pi_end_q, pi_end_d;
  logic        busy_q, busy_d;
  logic        done_q, done_d;
  logic        err_q, err_d;

  always_comb begin
    state_d     = state_q;
    cmd_addr_d  = cmd_addr_q;
    cmd_count_d = cmd_count_q;
    pi_data_d   = pi_data_q;
    pi_length_d = pi_length_q;
    pi_fill_d   = pi_fill_q;
    pi_msb_d    = pi_msb_q;
    pi_low_d    = pi_low_q;
    last_d      = last_q;
    timeout_d   = timeout_q;
    err_d       = err_q;

    case (state_q)
      S_IDLE, S_DONE: begin
        if (start) begin
          state_d     = S_FETCH;
          cmd_addr_d  = 8'd0;
          cmd_count_d = 9'd0;
          err_d       = 1'b0;
        end
      end
      S_FETCH: state_d = S_CAPTURE;
      S_CAPTURE: begin
        last_d      = cmd_rdata[21];
        pi_low_d    = cmd_rdata[20];
        pi_msb_d    = cmd_rdata[19];
        pi_fill_d   = cmd_rdata[18];
        pi_length_d = cmd_rdata[17:16];
        pi_data_d   = cmd_rdata[15:0];
        state_d     = S_LOAD;
      end
      S_LOAD: begin
        timeout_d = 3'd0;
        state_d   = S_WAIT_START;
      end
      S_WAIT_START: begin
        if (so_valid) begin
          state_d = S_WAIT_END;
        end else if (timeout_q == 3'd7) begin
          state_d = S_DONE;
          err_d   = 1'b1;
        end else begin
          timeout_d = timeout_q + 3'd1;
        end
      end
      S_WAIT_END: begin
        if (!so_valid) begin
          cmd_count_d = cmd_count_q + 9'd1;
          // Address 255 ends the run so the address never wraps.
          if (last_q || cmd_addr_q == 8'd255) begin
            state_d = S_END;
          end else begin
            cmd_addr_d = cmd_addr_q + 8'd1;
            state_d    = S_FETCH;
          end
        end
      end
      S_END: begin
        if (pixel_finish) state_d = S_DONE;
      end
      default: state_d = S_IDLE;
    endcase

    // Strobes and status are registered copies decoded from the next state.
    cmd_rd_d = (state_d == S_FETCH);
    load_d   = (state_d == S_LOAD);
    pi_end_d = (state_d == S_END);
    done_d   = (state_d == S_DONE);
    busy_d   = (state_d != S_IDLE) && (state_d != S_DONE);
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      state_q     <= S_IDLE;
      cmd_addr_q  <= 8'd0;
      cmd_count_q <= 9'd0;
      pi_data_q   <= 16'd0;
      pi_length_q <= 2'd0;
      pi_fill_q   <= 1'b0;
      pi_msb_q    <= 1'b0;
      pi_low_q    <= 1'b0;
      last_q      <= 1'b0;
      timeout_q   <= 3'd0;
      cmd_rd_q    <= 1'b0;
      load_q      <= 1'b0;
      pi_end_q    <= 1'b0;
      busy_q      <= 1'b0;
      done_q      <= 1'b0;
      err_q       <= 1'b0;
    end else begin
      state_q     <= state_d;
      cmd_addr_q  <= cmd_addr_d;
      cmd_count_q <= cmd_count_d;
      pi_data_q   <= pi_data_d;
      pi_length_q <= pi_length_d;
      pi_fill_q   <= pi_fill_d;
      pi_msb_q    <= pi_msb_d;
      pi_low_q    <= pi_low_d;
      last_q      <= last_d;
      timeout_q   <= timeout_d;
      cmd_rd_q    <= cmd_rd_d;
      load_q      <= load_d;
      pi_end_q    <= pi_end_d;
      busy_q      <= busy_d;
      done_q      <= done_d;
      err_q       <= err_d;
    end
  end

  assign cmd_addr  = cmd_addr_q;
  assign cmd_count = cmd_count_q;
  assign cmd_rd    = cmd_rd_q;
  assign load      = load_q;
  assign pi_end    = pi_end_q;
  assign pi_data   = pi_data_q;
  assign pi_length = pi_length_q;
  assign pi_fill   = pi_fill_q;
  assign pi_msb    = pi_msb_q;
  assign pi_low    = pi_low_q;
  assign busy      = busy_q;
  assign done      = done_q;
  assign err       = err_q;

endmodule

// File: tb/tb_sti_feeder.sv
// Bench for sti_feeder: command memory, transmitter and pixel-arranger models
// with a scoreboard of expected words checked at every load pulse.
module tb_sti_feeder;

  logic        clk = 1'b0;
  logic        reset = 1'b0;
  logic        start = 1'b0;
  logic [7:0]  cmd_addr;
  logic        cmd_rd;
  logic [21:0] cmd_rdata = 22'd0;
  logic        load, pi_low, pi_msb, pi_fill, pi_end;
  logic [1:0]  pi_length;
  logic [15:0] pi_data;
  logic        so_valid = 1'b0;
  logic        pixel_finish = 1'b0;
  logic        busy, done, err;
  logic [8:0]  cmd_count;

  sti_feeder dut (
    .clk(clk), .reset(reset), .start(start),
    .cmd_addr(cmd_addr), .cmd_rd(cmd_rd), .cmd_rdata(cmd_rdata),
    .load(load), .pi_low(pi_low), .pi_msb(pi_msb), .pi_fill(pi_fill), .pi_end(pi_end),
    .pi_length(pi_length), .pi_data(pi_data),
    .so_valid(so_valid), .pixel_finish(pixel_finish),
    .busy(busy), .done(done), .err(err), .cmd_count(cmd_count)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic [7:0]  addr;
    logic [21:0] word;
  } exp_t;

  exp_t        exp_q[$];
  exp_t        exp_e;
  logic [21:0] mem [256];
  logic [20:0] obs;
  logic [20:0] cur = 21'd0;
  int          checks = 0;
  int          errors = 0;
  int          load_cnt = 0;
  int          pend_cnt = 0;
  int          tx_wait = 0;
  int          tx_hold = 0;
  int          fin_cnt = 0;
  bit          tx_en = 1'b1;

  // Memory, transmitter and pixel-arranger models react on the falling edge.
  always @(negedge clk) begin
    if (cmd_rd === 1'b1) cmd_rdata = mem[cmd_addr];
    if (load === 1'b1 && tx_en) begin
      tx_wait = 2;
    end else if (tx_wait > 0) begin
      tx_wait--;
      if (tx_wait == 0) begin
        so_valid = 1'b1;
        tx_hold  = 3;
      end
    end else if (tx_hold > 0) begin
      tx_hold--;
      if (tx_hold == 0) so_valid = 1'b0;
    end
    if (pi_end === 1'b1) begin
      fin_cnt++;
      if (fin_cnt >= 3) pixel_finish = 1'b1;
    end else begin
      fin_cnt      = 0;
      pixel_finish = 1'b0;
    end
  end

  // Scoreboard monitor, sampled just after each rising edge.
  always @(posedge clk) begin
    #1;
    obs = {pi_low, pi_msb, pi_fill, pi_length, pi_data};
    if (load === 1'b1) begin
      load_cnt++;
      checks++;
      if (exp_q.size() == 0) begin
        errors++;
        $display("FAIL load_unexpected: load at addr %0d, required no load", cmd_addr);
      end else begin
        exp_e = exp_q.pop_front();
        if ({cmd_addr, obs} !== {exp_e.addr, exp_e.word[20:0]}) begin
          errors++;
          $display("FAIL load_word: addr %0d word %h, required addr %0d word %h",
                   cmd_addr, obs, exp_e.addr, exp_e.word[20:0]);
        end
      end
      cur = obs;
    end
    if (so_valid === 1'b1 && busy === 1'b1) begin
      checks++;
      if (obs !== cur) begin
        errors++;
        $display("FAIL pi_stable: fields %h during so_valid, required %h", obs, cur);
      end
    end
    if (pi_end === 1'b1) pend_cnt++;
    checks++;
    if (load === 1'b1 && (so_valid === 1'b1 || pi_end === 1'b1)) begin
      errors++;
      $display("FAIL load_overlap: load=%b so_valid=%b pi_end=%b, required load alone",
               load, so_valid, pi_end);
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic pulse_start();
    start = 1'b1;
    tick();
    start = 1'b0;
  endtask

  task automatic clear_mem();
    for (int i = 0; i < 256; i++) mem[i] = 22'd0;
  endtask

  task automatic expect_cmd(input int a);
    exp_t e;
    e.addr = 8'(a);
    e.word = mem[a];
    exp_q.push_back(e);
  endtask

  task automatic wait_done(input int budget, input string name);
    int n = 0;
    while (done !== 1'b1 && n < budget) begin
      tick();
      n++;
    end
    checks++;
    if (done !== 1'b1) begin
      errors++;
      $display("FAIL %s_done: done=%b after %0d cycles, required 1", name, done, budget);
    end
  endtask

  task automatic wait_so_valid(input int budget, input logic [7:0] at_addr, input string name);
    int n = 0;
    while (!(so_valid === 1'b1 && cmd_addr === at_addr) && n < budget) begin
      tick();
      n++;
    end
    checks++;
    if (so_valid !== 1'b1) begin
      errors++;
      $display("FAIL %s_so_valid: so_valid=%b at addr %0d, required 1 at addr %0d",
               name, so_valid, cmd_addr, at_addr);
    end
  endtask

  task automatic test_reset();
    start = 1'b1;
    tick();
    tick();
    checks++;
    if ({cmd_addr, cmd_rd, load, pi_low, pi_msb, pi_fill, pi_end, pi_length, pi_data,
         busy, done, err, cmd_count} !== 44'd0) begin
      errors++;
      $display("FAIL reset_outputs: addr=%0d rd=%b load=%b data=%h busy=%b done=%b err=%b cnt=%0d, required all 0",
               cmd_addr, cmd_rd, load, pi_data, busy, done, err, cmd_count);
    end
    start = 1'b0;
    reset = 1'b1;
    tick();
    checks++;
    if (busy !== 1'b0) begin
      errors++;
      $display("FAIL reset_idle: busy=%b, required 0", busy);
    end
  endtask

  task automatic test_single();
    clear_mem();
    mem[0] = {1'b1, 1'b0, 1'b1, 1'b0, 2'b00, 16'hA5C3};
    expect_cmd(0);
    load_cnt = 0;
    pend_cnt = 0;
    pulse_start();
    checks++;
    if ({cmd_rd, cmd_addr, busy} !== {1'b1, 8'd0, 1'b1}) begin
      errors++;
      $display("FAIL single_fetch: rd=%b addr=%0d busy=%b, required 1 0 1", cmd_rd, cmd_addr, busy);
    end
    tick();
    checks++;
    if ({cmd_rd, load} !== 2'b00) begin
      errors++;
      $display("FAIL single_capture: rd=%b load=%b, required 0 0", cmd_rd, load);
    end
    tick();
    checks++;
    if ({load, pi_data} !== {1'b1, 16'hA5C3}) begin
      errors++;
      $display("FAIL single_load: load=%b data=%h, required 1 a5c3", load, pi_data);
    end
    wait_done(100, "single");
    checks++;
    if ({cmd_count, err, busy, pi_end} !== {9'd1, 1'b0, 1'b0, 1'b0} || load_cnt != 1 || pend_cnt < 1) begin
      errors++;
      $display("FAIL single_end: cnt=%0d err=%b busy=%b pi_end=%b loads=%0d pend=%0d, required 1 0 0 0 1 >=1",
               cmd_count, err, busy, pi_end, load_cnt, pend_cnt);
    end
  endtask

  task automatic test_three();
    clear_mem();
    mem[0] = {1'b0, 1'b1, 1'b0, 1'b1, 2'b01, 16'h1234};
    mem[1] = {1'b0, 1'b0, 1'b1, 1'b1, 2'b10, 16'hBEEF};
    mem[2] = {1'b1, 1'b1, 1'b1, 1'b0, 2'b11, 16'h0F0F};
    for (int i = 0; i < 3; i++) expect_cmd(i);
    load_cnt = 0;
    pulse_start();
    wait_done(200, "three");
    checks++;
    if (load_cnt != 3 || cmd_addr !== 8'd2 || cmd_count !== 9'd3 || exp_q.size() != 0) begin
      errors++;
      $display("FAIL three_end: loads=%0d addr=%0d cnt=%0d pending=%0d, required 3 2 3 0",
               load_cnt, cmd_addr, cmd_count, exp_q.size());
    end
  endtask

  task automatic test_timeout();
    clear_mem();
    mem[0] = {1'b1, 1'b0, 1'b0, 1'b1, 2'b10, 16'h00FF};
    expect_cmd(0);
    tx_en = 1'b0;
    pend_cnt = 0;
    pulse_start();
    tick();
    tick();
    checks++;
    if (load !== 1'b1) begin
      errors++;
      $display("FAIL timeout_load: load=%b, required 1", load);
    end
    tick();
    repeat (7) tick();
    checks++;
    if ({done, err, busy} !== 3'b001) begin
      errors++;
      $display("FAIL timeout_early: done=%b err=%b busy=%b after 7 cycles, required 0 0 1", done, err, busy);
    end
    tick();
    checks++;
    if ({done, err, busy, cmd_count} !== {3'b110, 9'd0} || pend_cnt != 0) begin
      errors++;
      $display("FAIL timeout_err: done=%b err=%b busy=%b cnt=%0d pend=%0d after 8 cycles, required 1 1 0 0 0",
               done, err, busy, cmd_count, pend_cnt);
    end
    tx_en = 1'b1;
  endtask

  task automatic test_start_ignored();
    clear_mem();
    mem[0] = {1'b0, 1'b0, 1'b1, 1'b0, 2'b01, 16'hC001};
    mem[1] = {1'b1, 1'b1, 1'b0, 1'b0, 2'b00, 16'hC002};
    expect_cmd(0);
    expect_cmd(1);
    load_cnt = 0;
    pulse_start();
    checks++;
    if ({done, err, busy} !== 3'b001) begin
      errors++;
      $display("FAIL restart_clear: done=%b err=%b busy=%b, required 0 0 1", done, err, busy);
    end
    wait_so_valid(60, 8'd1, "ignore");
    pulse_start();
    wait_done(200, "ignore");
    checks++;
    if (load_cnt != 2 || cmd_count !== 9'd2 || cmd_addr !== 8'd1) begin
      errors++;
      $display("FAIL ignore_start: loads=%0d cnt=%0d addr=%0d, required 2 2 1", load_cnt, cmd_count, cmd_addr);
    end
    expect_cmd(0);
    expect_cmd(1);
    pulse_start();
    checks++;
    if ({done, err, busy, cmd_addr, cmd_count} !== {3'b001, 8'd0, 9'd0}) begin
      errors++;
      $display("FAIL done_restart: done=%b err=%b busy=%b addr=%0d cnt=%0d, required 0 0 1 0 0",
               done, err, busy, cmd_addr, cmd_count);
    end
    wait_done(200, "rerun");
    checks++;
    if (cmd_count !== 9'd2 || err !== 1'b0 || load_cnt != 4) begin
      errors++;
      $display("FAIL rerun_end: cnt=%0d err=%b loads=%0d, required 2 0 4", cmd_count, err, load_cnt);
    end
  endtask

  task automatic test_reset_mid();
    clear_mem();
    mem[0] = {1'b0, 1'b1, 1'b1, 1'b1, 2'b11, 16'h7E57};
    expect_cmd(0);
    load_cnt = 0;
    pend_cnt = 0;
    pulse_start();
    wait_so_valid(60, 8'd0, "midrst");
    reset = 1'b0;
    start = 1'b1;
    tick();
    checks++;
    if ({cmd_addr, cmd_rd, load, pi_low, pi_msb, pi_fill, pi_end, pi_length, pi_data,
         busy, done, err, cmd_count} !== 44'd0) begin
      errors++;
      $display("FAIL midrst_outputs: addr=%0d load=%b data=%h busy=%b cnt=%0d, required all 0",
               cmd_addr, load, pi_data, busy, cmd_count);
    end
    tick();
    checks++;
    if ({busy, cmd_rd} !== 2'b00) begin
      errors++;
      $display("FAIL midrst_priority: busy=%b rd=%b with start during reset, required 0 0", busy, cmd_rd);
    end
    start = 1'b0;
    reset = 1'b1;
    repeat (6) tick();
    checks++;
    if (load_cnt != 1 || pend_cnt != 0 || busy !== 1'b0) begin
      errors++;
      $display("FAIL midrst_quiet: loads=%0d pend=%0d busy=%b, required 1 0 0", load_cnt, pend_cnt, busy);
    end
    mem[0] = {1'b1, 1'b0, 1'b0, 1'b0, 2'b01, 16'h3C3C};
    expect_cmd(0);
    pulse_start();
    checks++;
    if ({cmd_rd, cmd_addr} !== {1'b1, 8'd0}) begin
      errors++;
      $display("FAIL midrst_restart: rd=%b addr=%0d, required 1 0", cmd_rd, cmd_addr);
    end
    wait_done(100, "midrst");
    checks++;
    if (cmd_count !== 9'd1) begin
      errors++;
      $display("FAIL midrst_count: cnt=%0d, required 1", cmd_count);
    end
  endtask

  task automatic test_no_last();
    clear_mem();
    for (int i = 0; i < 256; i++) begin
      mem[i] = {1'b0, i[4], i[3], i[2], i[1:0], 16'(i * 257) ^ 16'h5A5A};
      expect_cmd(i);
    end
    load_cnt = 0;
    pend_cnt = 0;
    pulse_start();
    wait_done(5000, "nolast");
    checks++;
    if (load_cnt != 256 || cmd_addr !== 8'd255 || cmd_count !== 9'd256 || pend_cnt < 1 ||
        exp_q.size() != 0) begin
      errors++;
      $display("FAIL nolast_end: loads=%0d addr=%0d cnt=%0d pend=%0d pending=%0d, required 256 255 256 >=1 0",
               load_cnt, cmd_addr, cmd_count, pend_cnt, exp_q.size());
    end
  endtask

  initial begin
    clear_mem();
    test_reset();
    test_single();
    test_three();
    test_timeout();
    test_start_ignored();
    test_reset_mid();
    test_no_last();
    repeat (4) tick();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/sti_feeder.md
STI_FEEDER -- requirements
Module: sti_feeder

Interface
REQ-001 SHALL have port clk  input  1  single clock; all state updates on rising edge.
REQ-002 SHALL have port reset  input  1  synchronous, active-low reset (reset=0 sampled at a rising edge resets the block).
REQ-003 SHALL have port start  input  1  pulse; begins a command run when the block is in IDLE or DONE.
REQ-004 SHALL have port cmd_addr  output  8  command memory read address.
REQ-005 SHALL have port cmd_rd  output  1  command memory read strobe.
REQ-006 SHALL have port cmd_rdata  input  22  command word, valid exactly one cycle after cmd_rd: [21] last, [20] low, [19] msb, [18] fill, [17:16] length, [15:0] data.
REQ-007 SHALL have ports load, pi_low, pi_msb, pi_fill, pi_end  output  1 each  serial transmitter controls.
REQ-008 SHALL have ports pi_length  output  2  and  pi_data  output  16  serial transmitter word and format.
REQ-009 SHALL have port so_valid  input  1  serial-output-valid returned by the transmitter.
REQ-010 SHALL have port pixel_finish  input  1  frame-complete flag from the data arranger.
REQ-011 SHALL have ports busy, done, err  output  1 each  status.
REQ-012 SHALL have port cmd_count  output  9  number of commands fully transmitted in the current run.

Function
REQ-013 SHALL implement states IDLE, FETCH, CAPTURE, LOAD, WAIT_START, WAIT_END, END, DONE.
REQ-014 IDLE: start=1 -> FETCH, cmd_addr<=0, cmd_count<=0, err<=0, done<=0.
REQ-015 FETCH: cmd_rd=1 for this single cycle -> CAPTURE.
REQ-016 CAPTURE: register cmd_rdata fields into pi_data/pi_length/pi_fill/pi_msb/pi_low and an internal last flag -> LOAD.
REQ-017 LOAD: load=1 for exactly one cycle -> WAIT_START; timeout counter cleared to 0.
REQ-018 WAIT_START: so_valid=1 -> WAIT_END; otherwise increment timeout; when timeout reaches 7 with so_valid=0, -> DONE with err<=1.
REQ-019 WAIT_END: so_valid=0 -> cmd_count+1; if last=1 or cmd_addr=255 -> END, else cmd_addr+1 and -> FETCH.
REQ-020 cmd_addr SHALL never wrap; address 255 without last terminates the run as if last were set.
REQ-021 END: pi_end=1 held every cycle until pixel_finish=1 sampled -> DONE, pi_end<=0.
REQ-022 DONE: done=1 held; start=1 -> FETCH with the same initialisation as REQ-014.
REQ-023 busy SHALL be 1 in every state except IDLE and DONE.
REQ-024 pi_data, pi_length, pi_fill, pi_msb, pi_low SHALL stay constant from CAPTURE until the next CAPTURE (transmitter samples pi_data throughout the transfer).
REQ-025 start SHALL be ignored while busy=1.
REQ-026 load and pi_end SHALL never be 1 in the same cycle; load SHALL never be 1 while so_valid=1.
REQ-027 Outputs SHALL be registered (no combinational path from any input to any output).

Reset
REQ-028 On reset=0 at a rising edge: state<=IDLE; cmd_addr, cmd_count, pi_data, pi_length <=0; load, cmd_rd, pi_fill, pi_msb, pi_low, pi_end, busy, done, err <=0.
REQ-029 Reset SHALL take effect from any state, including mid-transfer, with no further load/pi_end issued; reset has priority over start.

Verification
REQ-030 Single command {last=1, len=00, msb=1, low=0, data=16'hA5C3}: start -> cmd_rd at addr 0, load one cycle later than CAPTURE, pi_data=16'hA5C3 stable through so_valid high period, pi_end after so_valid falls, done=1 after pixel_finish, cmd_count=1.
REQ-031 Three commands at addr 0..2 (len 01, 10, 11; last only on addr 2): exactly three load pulses, each issued only after so_valid low, cmd_addr ends at 2, cmd_count=3.
REQ-032 Transmitter model never raises so_valid: err=1 and done=1 exactly 8 cycles after WAIT_START entry; pi_end never asserted.
REQ-033 Memory with last=0 everywhere: 256 loads issued, cmd_addr stops at 255 (no wrap to 0), then pi_end until pixel_finish, cmd_count=256.
REQ-034 reset=0 asserted while so_valid=1 in WAIT_END: all outputs at reset values next cycle; start asserted after reset release restarts at cmd_addr=0.
REQ-035 start pulsed during WAIT_END and again in DONE: first ignored, second restarts run with done and err cleared.
